// File: rtl/rs_issue_sched.sv
// Reservation-station scheduler: buffers ALU/branch micro-ops, wakes operands from the ALU/LSB CDBs,
// and issues the lowest-index ready entry each cycle. Define RS_DISPATCH_BYPASS_EN to issue ready dispatches directly.
module rs_issue_sched #(
  parameter int RS_SIZE    = 16,
  parameter int RS_ID_LEN  = 4,
  parameter int OPENUM_LEN = 6,
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32,
  parameter int ROB_ID_LEN = 4,
  parameter logic [OPENUM_LEN-1:0] OPENUM_NOP = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  disp_valid,
  input  logic [OPENUM_LEN-1:0] disp_openum,
  input  logic [DATA_LEN-1:0]   disp_imm,
  input  logic [ADDR_LEN-1:0]   disp_pc,
  input  logic [ROB_ID_LEN-1:0] disp_rob_id,
  input  logic [DATA_LEN-1:0]   disp_V1,
  input  logic [DATA_LEN-1:0]   disp_V2,
  input  logic [ROB_ID_LEN-1:0] disp_Q1,
  input  logic [ROB_ID_LEN-1:0] disp_Q2,
  input  logic                  disp_P1,
  input  logic                  disp_P2,
  input  logic                  alu_cdb_valid,
  input  logic [ROB_ID_LEN-1:0] alu_cdb_rob_id,
  input  logic [DATA_LEN-1:0]   alu_cdb_result,
  input  logic                  lsb_cdb_valid,
  input  logic [ROB_ID_LEN-1:0] lsb_cdb_rob_id,
  input  logic [DATA_LEN-1:0]   lsb_cdb_result,
  output logic                  full,
  output logic [OPENUM_LEN-1:0] ex_openum,
  output logic [DATA_LEN-1:0]   ex_V1,
  output logic [DATA_LEN-1:0]   ex_V2,
  output logic [DATA_LEN-1:0]   ex_imm,
  output logic [ADDR_LEN-1:0]   ex_pc,
  output logic [ROB_ID_LEN-1:0] ex_rob_id
);

  logic [RS_SIZE-1:0]    busy_q, busy_d;
  logic [RS_SIZE-1:0]    p1_q, p1_d;
  logic [RS_SIZE-1:0]    p2_q, p2_d;
  logic [OPENUM_LEN-1:0] openum_q [RS_SIZE];
  logic [OPENUM_LEN-1:0] openum_d [RS_SIZE];
  logic [DATA_LEN-1:0]   v1_q [RS_SIZE];
  logic [DATA_LEN-1:0]   v1_d [RS_SIZE];
  logic [DATA_LEN-1:0]   v2_q [RS_SIZE];
  logic [DATA_LEN-1:0]   v2_d [RS_SIZE];
  logic [ROB_ID_LEN-1:0] q1_q [RS_SIZE];
  logic [ROB_ID_LEN-1:0] q1_d [RS_SIZE];
  logic [ROB_ID_LEN-1:0] q2_q [RS_SIZE];
  logic [ROB_ID_LEN-1:0] q2_d [RS_SIZE];
  logic [DATA_LEN-1:0]   imm_q [RS_SIZE];
  logic [DATA_LEN-1:0]   imm_d [RS_SIZE];
  logic [ADDR_LEN-1:0]   pc_q [RS_SIZE];
  logic [ADDR_LEN-1:0]   pc_d [RS_SIZE];
  logic [ROB_ID_LEN-1:0] rob_q [RS_SIZE];
  logic [ROB_ID_LEN-1:0] rob_d [RS_SIZE];

  logic [OPENUM_LEN-1:0] ex_openum_q, ex_openum_d;
  logic [DATA_LEN-1:0]   ex_v1_q, ex_v1_d;
  logic [DATA_LEN-1:0]   ex_v2_q, ex_v2_d;
  logic [DATA_LEN-1:0]   ex_imm_q, ex_imm_d;
  logic [ADDR_LEN-1:0]   ex_pc_q, ex_pc_d;
  logic [ROB_ID_LEN-1:0] ex_rob_q, ex_rob_d;

  logic [RS_SIZE-1:0]   ready;
  logic                 sel_found;
  logic [RS_ID_LEN-1:0] sel_idx;
  logic [RS_ID_LEN-1:0] free_idx;
  logic                 disp_fire;
  logic                 bypass;
  logic [DATA_LEN-1:0]  cap_v1, cap_v2;
  logic                 cap_p1, cap_p2;

  // Priority encoders and dispatch-time operand capture, all from registered state.
  always_comb begin
    full      = &busy_q;
    ready     = busy_q & ~p1_q & ~p2_q;
    sel_found = |ready;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = RS_ID_LEN'(i);
      if (!busy_q[i]) free_idx = RS_ID_LEN'(i);
    end

    cap_v1 = disp_V1;
    cap_p1 = disp_P1;
    if (disp_P1 && alu_cdb_valid && alu_cdb_rob_id == disp_Q1) begin
      cap_v1 = alu_cdb_result;
      cap_p1 = 1'b0;
    end else if (disp_P1 && lsb_cdb_valid && lsb_cdb_rob_id == disp_Q1) begin
      cap_v1 = lsb_cdb_result;
      cap_p1 = 1'b0;
    end

    cap_v2 = disp_V2;
    cap_p2 = disp_P2;
    if (disp_P2 && alu_cdb_valid && alu_cdb_rob_id == disp_Q2) begin
      cap_v2 = alu_cdb_result;
      cap_p2 = 1'b0;
    end else if (disp_P2 && lsb_cdb_valid && lsb_cdb_rob_id == disp_Q2) begin
      cap_v2 = lsb_cdb_result;
      cap_p2 = 1'b0;
    end

    disp_fire = disp_valid && !full && rdy && !flush;
`ifdef RS_DISPATCH_BYPASS_EN
    bypass = disp_fire && !sel_found && !cap_p1 && !cap_p2;
`else
    bypass = 1'b0;
`endif
  end

  // Next-state: flush beats everything, rdy low freezes, otherwise wakeup, select and dispatch.
  always_comb begin
    busy_d      = busy_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    openum_d    = openum_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    rob_d       = rob_q;
    ex_openum_d = ex_openum_q;
    ex_v1_d     = ex_v1_q;
    ex_v2_d     = ex_v2_q;
    ex_imm_d    = ex_imm_q;
    ex_pc_d     = ex_pc_q;
    ex_rob_d    = ex_rob_q;

    if (flush) begin
      busy_d      = '0;
      ex_openum_d = OPENUM_NOP;
    end else if (!rdy) begin
      ex_openum_d = OPENUM_NOP;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (p1_q[i]) begin
          if (alu_cdb_valid && alu_cdb_rob_id == q1_q[i]) begin
            v1_d[i] = alu_cdb_result;
            p1_d[i] = 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob_id == q1_q[i]) begin
            v1_d[i] = lsb_cdb_result;
            p1_d[i] = 1'b0;
          end
        end
        if (p2_q[i]) begin
          if (alu_cdb_valid && alu_cdb_rob_id == q2_q[i]) begin
            v2_d[i] = alu_cdb_result;
            p2_d[i] = 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob_id == q2_q[i]) begin
            v2_d[i] = lsb_cdb_result;
            p2_d[i] = 1'b0;
          end
        end
      end

      if (sel_found) begin
        busy_d[sel_idx] = 1'b0;
        ex_openum_d     = openum_q[sel_idx];
        ex_v1_d         = v1_q[sel_idx];
        ex_v2_d         = v2_q[sel_idx];
        ex_imm_d        = imm_q[sel_idx];
        ex_pc_d         = pc_q[sel_idx];
        ex_rob_d        = rob_q[sel_idx];
      end else if (bypass) begin
        ex_openum_d = disp_openum;
        ex_v1_d     = cap_v1;
        ex_v2_d     = cap_v2;
        ex_imm_d    = disp_imm;
        ex_pc_d     = disp_pc;
        ex_rob_d    = disp_rob_id;
      end else begin
        ex_openum_d = OPENUM_NOP;
      end

      // The free slot is never the selected one, so the write cannot collide with select.
      if (disp_fire && !bypass) begin
        busy_d[free_idx]   = 1'b1;
        openum_d[free_idx] = disp_openum;
        v1_d[free_idx]     = cap_v1;
        v2_d[free_idx]     = cap_v2;
        q1_d[free_idx]     = disp_Q1;
        q2_d[free_idx]     = disp_Q2;
        p1_d[free_idx]     = cap_p1;
        p2_d[free_idx]     = cap_p2;
        imm_d[free_idx]    = disp_imm;
        pc_d[free_idx]     = disp_pc;
        rob_d[free_idx]    = disp_rob_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      ex_openum_q <= OPENUM_NOP;
      ex_v1_q     <= '0;
      ex_v2_q     <= '0;
      ex_imm_q    <= '0;
      ex_pc_q     <= '0;
      ex_rob_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      ex_openum_q <= ex_openum_d;
      ex_v1_q     <= ex_v1_d;
      ex_v2_q     <= ex_v2_d;
      ex_imm_q    <= ex_imm_d;
      ex_pc_q     <= ex_pc_d;
      ex_rob_q    <= ex_rob_d;
    end
  end

  // Entry payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk) begin
    openum_q <= openum_d;
    v1_q     <= v1_d;
    v2_q     <= v2_d;
    q1_q     <= q1_d;
    q2_q     <= q2_d;
    imm_q    <= imm_d;
    pc_q     <= pc_d;
    rob_q    <= rob_d;
  end

  assign ex_openum = ex_openum_q;
  assign ex_V1     = ex_v1_q;
  assign ex_V2     = ex_v2_q;
  assign ex_imm    = ex_imm_q;
  assign ex_pc     = ex_pc_q;
  assign ex_rob_id = ex_rob_q;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed scoreboard bench for rs_issue_sched: expected issues are queued with their issue cycle
// and compared against ex_* every cycle; cycles with no expected issue must show NOP.
module tb_rs_issue_sched;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd2;
  localparam logic [5:0] OP_SUB  = 6'd3;
`ifdef RS_DISPATCH_BYPASS_EN
  localparam int READY_LAT = 1;
`else
  localparam int READY_LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        disp_valid;
  logic [5:0]  disp_openum;
  logic [31:0] disp_imm;
  logic [31:0] disp_pc;
  logic [3:0]  disp_rob_id;
  logic [31:0] disp_V1, disp_V2;
  logic [3:0]  disp_Q1, disp_Q2;
  logic        disp_P1, disp_P2;
  logic        alu_cdb_valid;
  logic [3:0]  alu_cdb_rob_id;
  logic [31:0] alu_cdb_result;
  logic        lsb_cdb_valid;
  logic [3:0]  lsb_cdb_rob_id;
  logic [31:0] lsb_cdb_result;
  logic        full;
  logic [5:0]  ex_openum;
  logic [31:0] ex_V1, ex_V2, ex_imm, ex_pc;
  logic [3:0]  ex_rob_id;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  int   cyc;
  logic [3:0] pair_tags [6] = '{4'd1, 4'd2, 4'd8, 4'd3, 4'd4, 4'd8};

  rs_issue_sched #(
    .RS_SIZE(16), .RS_ID_LEN(4), .OPENUM_LEN(6), .DATA_LEN(32),
    .ADDR_LEN(32), .ROB_ID_LEN(4), .OPENUM_NOP(OP_NOP)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_openum(disp_openum), .disp_imm(disp_imm),
    .disp_pc(disp_pc), .disp_rob_id(disp_rob_id),
    .disp_V1(disp_V1), .disp_V2(disp_V2), .disp_Q1(disp_Q1), .disp_Q2(disp_Q2),
    .disp_P1(disp_P1), .disp_P2(disp_P2),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_result(alu_cdb_result),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_result(lsb_cdb_result),
    .full(full), .ex_openum(ex_openum), .ex_V1(ex_V1), .ex_V2(ex_V2),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rob_id(ex_rob_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                               input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob,
                               input logic [3:0] q1, input logic p1, input logic [3:0] q2, input logic p2);
    disp_valid  = 1'b1;
    disp_openum = op;
    disp_V1     = v1;
    disp_V2     = v2;
    disp_imm    = imm;
    disp_pc     = pc;
    disp_rob_id = rob;
    disp_Q1     = q1;
    disp_P1     = p1;
    disp_Q2     = q2;
    disp_P2     = p2;
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob,
                          input int at);
    exp_t e;
    e.op = op; e.v1 = v1; e.v2 = v2; e.imm = imm; e.pc = pc; e.rob = rob; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic alu_bcast(input logic v, input logic [3:0] tag, input logic [31:0] res);
    alu_cdb_valid  = v;
    alu_cdb_rob_id = tag;
    alu_cdb_result = res;
  endtask

  task automatic lsb_bcast(input logic v, input logic [3:0] tag, input logic [31:0] res);
    lsb_cdb_valid  = v;
    lsb_cdb_rob_id = tag;
    lsb_cdb_result = res;
  endtask

  // One clock: advance past the rising edge, then compare ex_* on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checkOutput("issue_op",  32'(ex_openum), 32'(e.op));
      checkOutput("issue_v1",  ex_V1, e.v1);
      checkOutput("issue_v2",  ex_V2, e.v2);
      checkOutput("issue_imm", ex_imm, e.imm);
      checkOutput("issue_pc",  ex_pc, e.pc);
      checkOutput("issue_rob", 32'(ex_rob_id), 32'(e.rob));
    end else begin
      checkOutput("idle_nop", 32'(ex_openum), 32'(OP_NOP));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b0;
    rdy      = 1'b1;
    flush    = 1'b0;
    applyStimulus(OP_NOP, 0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    disp_valid = 1'b0;
    alu_bcast(1'b0, 0, 0);
    lsb_bcast(1'b0, 0, 0);

    // Reset and idle
    tick(); tick(); tick();
    checkOutput("rst_full",  32'(full), 32'd0);
    checkOutput("rst_v1",    ex_V1, 32'd0);
    checkOutput("rst_imm",   ex_imm, 32'd0);
    checkOutput("rst_rob",   32'(ex_rob_id), 32'd0);
    rst = 1'b1;
    tick();

    // ADDI with ready operands
    applyStimulus(OP_ADDI, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
    push_exp(OP_ADDI, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3, cyc + READY_LAT);
    tick();
    disp_valid = 1'b0;
    tick(); tick();
    checkOutput("ex_v1_hold",  ex_V1, 32'd5);
    checkOutput("ex_rob_hold", 32'(ex_rob_id), 32'd3);

    // ADD waiting on tag 6, woken by the LSB bus two cycles later
    applyStimulus(OP_ADD, 32'd0, 32'd3, 32'd0, 32'h104, 4'd4, 4'd6, 1'b1, 4'd0, 1'b0);
    tick();
    disp_valid = 1'b0;
    tick();
    lsb_bcast(1'b1, 4'd6, 32'h10);
    push_exp(OP_ADD, 32'h10, 32'd3, 32'd0, 32'h104, 4'd4, cyc + 2);
    tick();
    lsb_bcast(1'b0, 0, 0);
    tick(); tick();

    // Dispatch-time capture on both operands, both buses matching: ALU wins
    applyStimulus(OP_SUB, 32'd0, 32'd0, 32'd0, 32'h108, 4'd5, 4'd7, 1'b1, 4'd7, 1'b1);
    alu_bcast(1'b1, 4'd7, 32'h22);
    lsb_bcast(1'b1, 4'd7, 32'h33);
    push_exp(OP_SUB, 32'h22, 32'h22, 32'd0, 32'h108, 4'd5, cyc + READY_LAT);
    tick();
    disp_valid = 1'b0;
    alu_bcast(1'b0, 0, 0);
    lsb_bcast(1'b0, 0, 0);
    tick(); tick();

    // Fill all 16 entries with pending ops, then try a 17th
    for (int i = 0; i < 16; i++) begin
      applyStimulus(OP_ADD, 32'd0, 32'(i), 32'd0, 32'h200 + 32'(4 * i), 4'(i), 4'(i), 1'b1, 4'd0, 1'b0);
      tick();
    end
    checkOutput("full_set", 32'(full), 32'd1);
    applyStimulus(OP_ADDI, 32'd1, 32'd0, 32'h99, 32'h300, 4'd15, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    disp_valid = 1'b0;
    tick();
    alu_bcast(1'b1, 4'd9, 32'h90);
    push_exp(OP_ADD, 32'h90, 32'd9, 32'd0, 32'h224, 4'd9, cyc + 2);
    tick();
    alu_bcast(1'b0, 0, 0);
    checkOutput("full_before_issue", 32'(full), 32'd1);
    tick();
    checkOutput("full_cleared", 32'(full), 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    // Entries 2 and 5 woken together: lowest index first
    for (int i = 0; i < 6; i++) begin
      applyStimulus(OP_ADD, 32'd0, 32'(i), 32'd0, 32'h400 + 32'(4 * i), 4'(10 + i), pair_tags[i], 1'b1, 4'd0, 1'b0);
      tick();
    end
    disp_valid = 1'b0;
    tick();
    alu_bcast(1'b1, 4'd8, 32'h55);
    push_exp(OP_ADD, 32'h55, 32'd2, 32'd0, 32'h408, 4'd12, cyc + 2);
    push_exp(OP_ADD, 32'h55, 32'd5, 32'd0, 32'h414, 4'd15, cyc + 3);
    tick();
    alu_bcast(1'b0, 0, 0);
    tick(); tick(); tick();

    // Flush together with a ready dispatch and a matching CDB
    flush = 1'b1;
    applyStimulus(OP_ADDI, 32'd1, 32'd0, 32'd1, 32'h500, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0);
    lsb_bcast(1'b1, 4'd1, 32'h77);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    lsb_bcast(1'b0, 0, 0);
    for (int t = 1; t <= 4; t++) begin
      alu_bcast(1'b1, 4'(t), 32'h1000 + 32'(t));
      tick();
    end
    alu_bcast(1'b0, 0, 0);
    tick(); tick(); tick();
    checkOutput("flush_not_full", 32'(full), 32'd0);

    // Dispatch while rdy is low is ignored
    rdy = 1'b0;
    applyStimulus(OP_ADDI, 32'd2, 32'd0, 32'd2, 32'h600, 4'd8, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    disp_valid = 1'b0;
    rdy = 1'b1;
    tick(); tick(); tick();

    // Reset held three cycles mid-traffic discards pending entries
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_SUB, 32'd0, 32'd1, 32'd0, 32'h700 + 32'(4 * i), 4'(1 + i), 4'(5 + i), 1'b1, 4'd0, 1'b0);
      tick();
    end
    disp_valid = 1'b0;
    rst = 1'b0;
    alu_bcast(1'b1, 4'd5, 32'h5);
    tick();
    alu_bcast(1'b0, 0, 0);
    tick(); tick();
    checkOutput("midrst_full", 32'(full), 32'd0);
    checkOutput("midrst_v1",   ex_V1, 32'd0);
    checkOutput("midrst_pc",   ex_pc, 32'd0);
    rst = 1'b1;
    for (int t = 5; t <= 7; t++) begin
      alu_bcast(1'b1, 4'(t), 32'h2000 + 32'(t));
      tick();
    end
    alu_bcast(1'b0, 0, 0);
    tick(); tick(); tick();

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
# rs_issue_sched

Reservation-station scheduler that owns the shared execution unit. Buffers dispatched ALU/branch micro-ops, wakes pending operands from the two common data buses (ALU, LSB), selects one ready entry per cycle, and presents it on registered `ex_*` outputs that feed the combinational execute unit. It sits between the decoder/dispatcher and the execute unit; the execute unit's result returns on the ALU CDB.

## Interface
- `RS_SIZE`, 16: number of entries; power of two.
- `RS_ID_LEN`, 4: log2(`RS_SIZE`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `rdy` input 1: global enable; low means freeze.
- `flush` input 1: misprediction rollback; clears all entries.
- `disp_valid` input 1: dispatch request.
- `disp_openum` input `OPENUM_LEN`; `disp_imm` input `DATA_LEN`; `disp_pc` input `ADDR_LEN`; `disp_rob_id` input `ROB_ID_LEN`.
- `disp_V1`, `disp_V2` input `DATA_LEN`: operand values, meaningful only when not pending.
- `disp_Q1`, `disp_Q2` input `ROB_ID_LEN`: producer tags.
- `disp_P1`, `disp_P2` input 1: operand pending (tag valid).
- `alu_cdb_valid` input 1; `alu_cdb_rob_id` input `ROB_ID_LEN`; `alu_cdb_result` input `DATA_LEN`.
- `lsb_cdb_valid` input 1; `lsb_cdb_rob_id` input `ROB_ID_LEN`; `lsb_cdb_result` input `DATA_LEN`.
- `full` output 1: no free entry. Combinational from registered state.
- `ex_openum` output `OPENUM_LEN`; `ex_V1`, `ex_V2`, `ex_imm` output `DATA_LEN`; `ex_pc` output `ADDR_LEN`; `ex_rob_id` output `ROB_ID_LEN`: registered issue to the execute unit. `ex_openum` = `OPENUM_NOP` means no issue.

## Operation
- Entry state: `busy`, `openum`, `V1`/`V2`, `Q1`/`Q2`, `P1`/`P2`, `imm`, `pc`, `rob_id`. An entry is ready when `busy & !P1 & !P2`.
- Dispatch is accepted when `disp_valid & !full & rdy & !flush`. The entry is written into the lowest-index free slot. Dispatch while `full` is dropped silently; the dispatcher must stall on `full`.
- Wakeup, per entry and per operand: if `P` is set and a valid CDB tag equals `Q`, capture the CDB result into `V` and clear `P` at the edge.
  - ALU and LSB buses are checked independently.
  - When both match the same tag, ALU has priority.
- Dispatch-time capture: if a dispatched operand is pending and its tag matches a same-cycle valid CDB, the entry is written with the value and `P = 0`. This path is required to avoid a lost wakeup.
- Select: the lowest-index ready entry is chosen. Its fields are loaded into `ex_*` and `busy` is cleared at the same edge. If nothing is ready, `ex_openum <= OPENUM_NOP` and the other `ex_*` fields hold.
- Same-edge interactions:
  - An entry freed by select is not reusable by dispatch in the same cycle, because `full` uses current state.
  - An entry woken this cycle is not selectable until the next cycle.
- `flush`: at the edge, all `busy <= 0` and `ex_openum <= OPENUM_NOP`. It wins over dispatch, select and wakeup.
- `rdy` low: no state changes and `ex_openum <= OPENUM_NOP`; all other registers hold. CDB broadcasts during `rdy` low are ignored; the producer must hold them.
- Reset (`rst` = 0 at edge): all `busy` = 0, all `P` = 0, `ex_openum` = `OPENUM_NOP`, other `ex_*` = 0, `full` = 0. A reset mid-operation discards all entries.

## Timing
- Dispatch with both operands ready in cycle N: entry is ready in N+1, `ex_*` are valid during N+2. Minimum latency is 2.
- Operand pending, CDB broadcast in cycle M: captured at the end of M, selectable in M+1, `ex_*` valid in M+2.
- Throughput: one issue per cycle.
- `full` rises the cycle after the dispatch that fills the last slot, and falls the cycle after the select that frees a slot.

## Configuration
- `RS_DISPATCH_BYPASS_EN` defined: in cycle N, a dispatch whose operands are both ready (including via dispatch-time capture) issues directly to `ex_*` at the end of N (`ex_*` valid in N+1) and occupies no entry. This happens only when no stored entry is ready and `full` is low.
- Undefined: every dispatch goes through an entry; minimum latency is 2.

## Test plan
- Reset, then idle: `ex_openum` = `OPENUM_NOP`, `full` = 0. Hold reset low 3 cycles mid-traffic; all entries are cleared.
- Dispatch ADDI, `V1` = 5, `imm` = 7, `rob_id` = 3, no pending operands: `ex_openum` = ADDI, `ex_V1` = 5, `ex_imm` = 7, `ex_rob_id` = 3 two cycles later (one cycle later with bypass).
- Dispatch ADD with `P1` = 1, `Q1` = 6; two cycles later `lsb_cdb` broadcasts tag 6 with result 0x10: ADD issues with `ex_V1` = 0x10 two cycles after the broadcast. A CDB broadcast in the same cycle as dispatch is also captured.
- Fill 16 entries, all pending: `full` = 1; a 17th dispatch is dropped. Wake entry 9: it issues, then `full` = 0.
- Entries 2 and 5 ready together: entry 2 issues first, entry 5 next cycle.
- `flush` in the same cycle as a dispatch and a CDB match: all entries cleared, `ex_openum` = NOP next cycle, the dispatch is not stored.
